// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store unit with lane steering, extension, misalign and timeout
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  mem_read_i,
    input  logic [1:0]  mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, RESP} state_t;
    state_t state_q, state_d;
    logic we_q, uns_q, err_q;
    logic [1:0] size_q, size_in;
    logic [31:0] addr_q, wdata_q, rdata_q, cnt_q, shifted, load_val;
    logic accept, is_wr, bad, timeout, in_req;
    logic unused_bits;
    assign is_wr = |mem_write_i;
    assign size_in = is_wr ? mem_write_i : mem_read_i;
    // both or neither size code set is illegal; sizes must be naturally aligned
    assign bad = (is_wr == |mem_read_i) | (size_in == 2'b10 & addr_i[0]) | (size_in == 2'b11 & |addr_i[1:0]);
    assign accept = req_valid_i & req_ready_o;
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q + 32'd1 == TIMEOUT_CYCLES);
    assign shifted = bus_rdata_i >> {addr_q[1:0], 3'b000};
    assign load_val = size_q == 2'b01 ? {{24{shifted[7] & ~uns_q}}, shifted[7:0]} :
                      size_q == 2'b10 ? {{16{shifted[15] & ~uns_q}}, shifted[15:0]} : bus_rdata_i;
    assign unused_bits = ^{funct3_i[1:0], shifted[31:16]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (req_valid_i) state_d = bad ? RESP : REQ;
            REQ:      if (bus_gnt_i) state_d = WAIT_RSP;
            WAIT_RSP: if (bus_rvalid_i || timeout) state_d = RESP;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        in_req = state_q == REQ;
        req_ready_o = state_q == IDLE;
        done_o = state_q == RESP;
        err_o = done_o & err_q;
        rdata_o = rdata_q;
        bus_req_o = in_req;
        bus_we_o = in_req & we_q;
        bus_addr_o = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
        bus_be_o = !in_req ? 4'b0000 : size_q == 2'b01 ? 4'b0001 << addr_q[1:0] :
                   size_q == 2'b10 ? 4'b0011 << addr_q[1:0] : 4'b1111;
        bus_wdata_o = !in_req ? 32'd0 : size_q == 2'b01 ? {4{wdata_q[7:0]}} :
                      size_q == 2'b10 ? {2{wdata_q[15:0]}} : wdata_q;
    end

    // rdata_q only changes on the way into RESP so it holds between completions
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q <= 1'b0;
            uns_q <= 1'b0;
            err_q <= 1'b0;
            size_q <= 2'b00;
            addr_q <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= state_q == WAIT_RSP ? cnt_q + 32'd1 : 32'd0;
            if (accept) begin
                we_q <= is_wr;
                uns_q <= funct3_i[2];
                err_q <= bad;
                size_q <= size_in;
                addr_q <= addr_i;
                wdata_q <= wdata_i;
                if (bad) rdata_q <= 32'd0;
            end
            if (state_q == WAIT_RSP && bus_rvalid_i) begin
                err_q <= bus_err_i;
                rdata_q <= (bus_err_i | we_q) ? 32'd0 : load_val;
            end else if (state_q == WAIT_RSP && timeout) begin
                err_q <= 1'b1;
                rdata_q <= 32'd0;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench with a behavioural bus responder
module tb_load_store_unit;
    logic clk = 0, rst_ni = 0;
    logic req_valid = 0, req_ready, done, err, bus_req, bus_we, bus_gnt = 0, bus_rvalid = 0, bus_err = 0;
    logic [1:0] mem_read = 0, mem_write = 0;
    logic [2:0] funct3 = 0;
    logic [31:0] addr = 0, wdata = 0, rdata, bus_addr, bus_wdata, bus_rdata = 0;
    logic [3:0] bus_be;
    int cyc = 0, total = 0, bad = 0;

    typedef struct {bit we; bit [31:0] addr; bit [3:0] be; bit [31:0] wdata; bit [31:0] word; bit err; int gd; int rd; bit norsp;} bus_t;
    typedef struct {bit err; bit [31:0] rdata; int cyc;} exp_t;
    bus_t bq[$];
    exp_t sq[$];

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .mem_read_i(mem_read), .mem_write_i(mem_write), .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
        .done_o(done), .err_o(err), .rdata_o(rdata), .bus_req_o(bus_req), .bus_we_o(bus_we),
        .bus_addr_o(bus_addr), .bus_be_o(bus_be), .bus_wdata_o(bus_wdata), .bus_gnt_i(bus_gnt),
        .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata), .bus_err_i(bus_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference behaviour straight from the size/offset rules, using plain arithmetic
    task automatic model(input logic [1:0] mr, input logic [1:0] mw, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] word, input logic berr, output logic isbad,
                         output logic [31:0] rd, output logic [3:0] be, output logic [31:0] wrep, output logic we);
        int sz, off;
        logic [31:0] v;
        we = mw != 0;
        sz = we ? int'(mw) : int'(mr);
        off = int'(a % 4);
        isbad = ((mr != 0) == (mw != 0)) || (sz == 2 && off % 2 != 0) || (sz == 3 && off != 0);
        be = sz == 1 ? 4'(1 << off) : sz == 2 ? 4'(3 << off) : 4'hF;
        wrep = sz == 1 ? wd[7:0] * 32'h0101_0101 : sz == 2 ? wd[15:0] * 32'h0001_0001 : wd;
        v = word >> (8 * off);
        if (sz == 1) begin
            v &= 32'hFF;
            if (!f3[2] && v >= 128) v |= 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v &= 32'hFFFF;
            if (!f3[2] && v >= 32768) v |= 32'hFFFF_0000;
        end else v = word;
        rd = (isbad || berr || we) ? 32'd0 : v;
    endtask

    task automatic issue(input logic [1:0] mr, input logic [1:0] mw, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] word, input logic berr, input int gd, input int rdl,
                         input bit norsp, input bit lat_chk, input bit push_exp);
        logic isbad, we;
        logic [31:0] rd, wrep;
        logic [3:0] be;
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("ready_wait", {31'd0, req_ready}, 32'd1);
            return;
        end
        mem_read = mr; mem_write = mw; funct3 = f3; addr = a; wdata = wd; req_valid = 1;
        @(posedge clk);
        #1 req_valid = 0;
        model(mr, mw, f3, a, wd, word, berr, isbad, rd, be, wrep, we);
        if (!isbad) bq.push_back('{we, {a[31:2], 2'b00}, be, wrep, word, berr, gd, rdl, norsp});
        if (push_exp) sq.push_back('{isbad || berr || norsp, norsp ? 32'd0 : rd, lat_chk ? (isbad ? cyc : cyc + 2) : -1});
    endtask

    // bus responder: checks the request against the expectation, then grants and answers
    initial begin
        bus_t b;
        forever begin
            @(negedge clk);
            if (bus_req) begin
                if (bq.size() == 0) chk("spurious_bus_req", {31'd0, bus_req}, 32'd0);
                else begin
                    b = bq.pop_front();
                    chk("bus_we", {31'd0, bus_we}, {31'd0, b.we});
                    chk("bus_addr", bus_addr, b.addr);
                    chk("bus_be", {28'd0, bus_be}, {28'd0, b.be});
                    if (b.we) chk("bus_wdata", bus_wdata, b.wdata);
                    repeat (b.gd) begin
                        @(negedge clk);
                        chk("req_held", {31'd0, bus_req}, 32'd1);
                        chk("addr_held", bus_addr, b.addr);
                        chk("be_held", {28'd0, bus_be}, {28'd0, b.be});
                    end
                    bus_gnt = 1;
                    @(negedge clk);
                    bus_gnt = 0;
                    chk("req_drop", {31'd0, bus_req}, 32'd0);
                    if (!b.norsp) begin
                        repeat (b.rd) @(negedge clk);
                        bus_rvalid = 1; bus_rdata = b.word; bus_err = b.err;
                        @(negedge clk);
                        bus_rvalid = 0; bus_err = 0; bus_rdata = $urandom;
                    end
                end
            end
        end
    end

    // monitor: pops the scoreboard on every completion and checks rdata holding between them
    initial begin
        exp_t e;
        logic [31:0] held = 0;
        forever begin
            @(negedge clk);
            if (!rst_ni) held = 0;
            else if (done) begin
                if (sq.size() == 0) chk("spurious_done", {31'd0, done}, 32'd0);
                else begin
                    e = sq.pop_front();
                    chk("err", {31'd0, err}, {31'd0, e.err});
                    chk("rdata", rdata, e.rdata);
                    if (e.cyc >= 0) chk("latency", cyc, e.cyc);
                end
                held = rdata;
            end else begin
                chk("rdata_hold", rdata, held);
                chk("err_idle", {31'd0, err}, 32'd0);
            end
        end
    end

    initial begin
        int n;
        logic [1:0] mr, mw;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_be", {28'd0, bus_be}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        #2 rst_ni = 1;
        issue(2'b01, 2'b00, 3'b000, 32'h1003, 0, 32'h80FF_1234, 0, 0, 0, 0, 1, 1);
        issue(2'b10, 2'b00, 3'b101, 32'h2002, 0, 32'h8001_0000, 0, 0, 0, 0, 1, 1);
        issue(2'b10, 2'b00, 3'b001, 32'h2002, 0, 32'h8001_0000, 0, 1, 2, 0, 0, 1);
        issue(2'b00, 2'b01, 3'b000, 32'h3001, 32'h0000_00AB, 32'h1234_5678, 0, 0, 0, 0, 1, 1);
        issue(2'b11, 2'b00, 3'b010, 32'h4002, 0, 0, 0, 0, 0, 0, 1, 1);
        issue(2'b01, 2'b01, 3'b000, 32'h4000, 0, 0, 0, 0, 0, 0, 1, 1);
        issue(2'b00, 2'b00, 3'b000, 32'h4000, 0, 0, 0, 0, 0, 0, 1, 1);
        issue(2'b11, 2'b00, 3'b010, 32'h5000, 0, 32'hCAFE_F00D, 0, 5, 1, 0, 0, 1);
        issue(2'b11, 2'b00, 3'b010, 32'h6000, 0, 0, 0, 0, 0, 1, 0, 1);
        issue(2'b00, 2'b11, 3'b010, 32'h6004, 32'h1111_2222, 0, 1, 0, 0, 0, 1, 1);
        // abort a transaction in WAIT_RSP; the late response must be ignored
        issue(2'b11, 2'b00, 3'b010, 32'h7000, 0, 32'hDEAD_BEEF, 0, 0, 3, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_ni = 0;
        #1;
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        @(negedge clk);
        #2 rst_ni = 1;
        repeat (5) begin
            @(negedge clk);
            #1 chk("no_done_after_rst", {31'd0, done}, 32'd0);
        end
        for (int i = 0; i < 100; i++) begin
            n = int'($urandom_range(0, 9));
            mr = 0; mw = 0;
            if (n == 0) begin end
            else if (n == 1) begin mr = 2'($urandom_range(1, 3)); mw = 2'($urandom_range(1, 3)); end
            else if (n < 6) mr = 2'($urandom_range(1, 3));
            else mw = 2'($urandom_range(1, 3));
            issue(mr, mw, 3'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 0, 0, 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        n = 0;
        while ((sq.size() != 0 || bq.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_scoreboard", sq.size(), 32'd0);
        chk("drain_bus", bq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
